parity_scan_monitor: RTL and testbench

PARITY_SCAN_MONITOR -- requirements
Module: parity_scan_monitor

---
 rtl/parity_scan_monitor.sv | 122 ++++++++++++
 tb/tb_parity_scan_monitor.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_scan_monitor.sv
// Parity scan monitor: checks parity of fetched words over a sweep and logs mismatches in a FWFT FIFO.
// Optional macro PARITY_SCAN_SAT_EN makes err_count saturate at 15 instead of wrapping.
module parity_scan_monitor #(
    parameter int SWEEP_LEN = 16,
    parameter int LOG_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       in_valid,
    input  logic [3:0] in_addr,
    input  logic [7:0] in_data,
    input  logic       in_parity,
    input  logic       log_pop,
    output logic       busy,
    output logic       done,
    output logic [3:0] err_count,
    output logic [3:0] log_addr,
    output logic [7:0] log_data,
    output logic       log_empty,
    output logic       log_full,
    output logic       overflow
);

    // state  | meaning
    // S_IDLE | after reset, waiting for start
    // S_SCAN | accepting samples of the current sweep
    // S_DONE | sweep complete, results held until the next start
    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    localparam int PTR_W = $clog2(LOG_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = $clog2(SWEEP_LEN + 1);

    state_t state, state_nxt;

    logic [IDX_W-1:0] sample_idx;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] log_cnt;
    logic [11:0]      log_mem [LOG_DEPTH];
    logic [11:0]      log_head;

    logic sweep_start, accept, mismatch, last_sample;
    logic push_req, pop_ok, push_ok;

    assign sweep_start = start && (state != S_SCAN);
    assign accept      = (state == S_SCAN) && in_valid;
    assign mismatch    = (^in_data) != in_parity;
    assign last_sample = sample_idx == IDX_W'(SWEEP_LEN - 1);
    assign log_empty   = log_cnt == '0;
    assign log_full    = log_cnt == CNT_W'(LOG_DEPTH);
    assign push_req    = accept && mismatch;
    // The clearing edge of a new sweep takes priority over a pop.
    assign pop_ok      = log_pop && !log_empty && !sweep_start;
    assign push_ok     = push_req && (!log_full || pop_ok);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_SCAN;
            S_SCAN:  if (accept && last_sample) state_nxt = S_DONE;
            S_DONE:  if (start) state_nxt = S_SCAN;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            S_SCAN:  busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_idx <= '0;
            err_count  <= '0;
            overflow   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            log_cnt    <= '0;
        end else if (sweep_start) begin
            sample_idx <= '0;
            err_count  <= '0;
            overflow   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            log_cnt    <= '0;
        end else begin
            if (accept) sample_idx <= sample_idx + IDX_W'(1);
            if (push_req) begin
`ifdef PARITY_SCAN_SAT_EN
                if (err_count != 4'hF) err_count <= err_count + 4'd1;
`else
                err_count <= err_count + 4'd1;
`endif
                if (log_full && !log_pop) overflow <= 1'b1;
            end
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            log_cnt <= log_cnt + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    // Storage needs no reset: contents are only visible while log_cnt is non-zero.
    always_ff @(posedge clk) begin
        if (push_ok) log_mem[wr_ptr] <= {in_addr, in_data};
    end

    assign log_head = log_mem[rd_ptr];
    assign log_addr = log_empty ? 4'h0 : log_head[11:8];
    assign log_data = log_empty ? 8'h00 : log_head[7:0];

endmodule

// File: tb/tb_parity_scan_monitor.sv
// Self-checking bench for parity_scan_monitor: directed sweeps plus random traffic against a queue-based model.
module tb_parity_scan_monitor;

    localparam int SWEEP_LEN = 16;
    localparam int LOG_DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset, start, in_valid, in_parity, log_pop;
    logic [3:0] in_addr;
    logic [7:0] in_data;
    logic       busy, done, log_empty, log_full, overflow;
    logic [3:0] err_count, log_addr;
    logic [7:0] log_data;

    int total = 0;
    int bad   = 0;

    // Reference model: sweep phase (0 idle, 1 scanning, 2 finished), counters and a queue of logged words.
    int         m_phase, m_idx, m_err;
    bit         m_ovf;
    logic [11:0] m_q[$];

    parity_scan_monitor #(.SWEEP_LEN(SWEEP_LEN), .LOG_DEPTH(LOG_DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_addr(in_addr), .in_data(in_data), .in_parity(in_parity), .log_pop(log_pop),
        .busy(busy), .done(done), .err_count(err_count), .log_addr(log_addr),
        .log_data(log_data), .log_empty(log_empty), .log_full(log_full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic good_par(input logic [7:0] d);
        return ^d;
    endfunction

    task automatic model_clear();
        m_phase = 0; m_idx = 0; m_err = 0; m_ovf = 0;
        m_q.delete();
    endtask

    // Drives one cycle of inputs, advances the model by the spec rules, then waits past the edge.
    task automatic step(input logic st, input logic v, input logic [3:0] a,
                        input logic [7:0] d, input logic p, input logic pop);
        start = st; in_valid = v; in_addr = a; in_data = d; in_parity = p; log_pop = pop;
        if (m_phase != 1 && st) begin
            m_phase = 1; m_idx = 0; m_err = 0; m_ovf = 0;
            m_q.delete();
        end else begin
            if (pop && m_q.size() > 0) void'(m_q.pop_front());
            if (m_phase == 1 && v) begin
                if ((^d) != p) begin
`ifdef PARITY_SCAN_SAT_EN
                    m_err = (m_err >= 15) ? 15 : m_err + 1;
`else
                    m_err = (m_err + 1) % 16;
`endif
                    if (m_q.size() < LOG_DEPTH) m_q.push_back({a, d});
                    else m_ovf = 1;
                end
                m_idx++;
                if (m_idx == SWEEP_LEN) m_phase = 2;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 0; in_valid = 0; in_addr = 0; in_data = 0; in_parity = 0; log_pop = 0;
        model_clear();
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 0; in_valid = 0; in_addr = 0; in_data = 0; in_parity = 0; log_pop = 0;
        model_clear();
        #2;
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0)      begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (err_count !== 4'h0) begin bad++; $display("FAIL reset_err got=%0d exp=0", err_count); end
        total++; if (log_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", log_empty); end
        total++; if (log_full !== 1'b0)  begin bad++; $display("FAIL reset_full got=%b exp=0", log_full); end
        total++; if (overflow !== 1'b0)  begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        total++; if ({log_addr, log_data} !== 12'h000) begin bad++; $display("FAIL reset_head got=%h exp=000", {log_addr, log_data}); end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        // in_valid with mismatches before any start must be ignored
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'(i), 8'h01, 1'b0, 1'b0);
        total++; if (busy !== 1'b0 || err_count !== 4'h0 || log_empty !== 1'b1)
            begin bad++; $display("FAIL idle_ignores_valid got busy=%b err=%0d empty=%b exp 0/0/1", busy, err_count, log_empty); end
    endtask

    task automatic test_clean_sweep();
        logic [7:0] d;
        do_reset();
        step(1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL clean_busy got=%b exp=1", busy); end
        for (int i = 0; i < SWEEP_LEN; i++) begin
            d = (i % 2 == 0) ? 8'h1F : 8'h22;
            step(1'b0, 1'b1, 4'(i), d, good_par(d), 1'b0);
            if (i == SWEEP_LEN - 2) begin
                total++; if (done !== 1'b0) begin bad++; $display("FAIL clean_early_done got=%b exp=0", done); end
            end
        end
        total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL clean_done got done=%b busy=%b exp 1/0", done, busy); end
        total++; if (err_count !== 4'h0) begin bad++; $display("FAIL clean_err got=%0d exp=0", err_count); end
        total++; if (log_empty !== 1'b1 || overflow !== 1'b0) begin bad++; $display("FAIL clean_log got empty=%b ovf=%b exp 1/0", log_empty, overflow); end
        // extra valid samples in DONE are ignored
        step(1'b0, 1'b1, 4'h5, 8'h01, 1'b0, 1'b0);
        total++; if (err_count !== 4'h0 || done !== 1'b1) begin bad++; $display("FAIL done_ignores_valid got err=%0d done=%b exp 0/1", err_count, done); end
    endtask

    task automatic test_two_errors();
        logic [7:0] d;
        logic       p;
        step(1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);   // restart from DONE
        for (int i = 0; i < SWEEP_LEN; i++) begin
            d = 8'(i * 7 + 3);
            p = good_par(d);
            if (i == 3) begin d = 8'h75; p = 1'b0; end
            if (i == 9) begin d = 8'h22; p = 1'b1; end
            // start mid-sweep must be ignored
            step(i == 5, 1'b1, 4'(i), d, p, 1'b0);
            if (i == 3) begin
                total++; if ({log_addr, log_data} !== 12'h375 || log_empty !== 1'b0)
                    begin bad++; $display("FAIL fwft_head got=%h empty=%b exp=375/0", {log_addr, log_data}, log_empty); end
            end
        end
        total++; if (err_count !== 4'd2) begin bad++; $display("FAIL two_err_count got=%0d exp=2", err_count); end
        total++; if ({log_addr, log_data} !== 12'h375) begin bad++; $display("FAIL two_head0 got=%h exp=375", {log_addr, log_data}); end
        step(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1);
        total++; if ({log_addr, log_data} !== 12'h922) begin bad++; $display("FAIL two_head1 got=%h exp=922", {log_addr, log_data}); end
        step(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1);
        total++; if (log_empty !== 1'b1 || {log_addr, log_data} !== 12'h000)
            begin bad++; $display("FAIL two_drained got empty=%b head=%h exp 1/000", log_empty, {log_addr, log_data}); end
        step(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1);   // pop on empty is ignored
        total++; if (log_empty !== 1'b1 || log_full !== 1'b0) begin bad++; $display("FAIL pop_empty got empty=%b full=%b exp 1/0", log_empty, log_full); end
    endtask

    task automatic test_overflow();
        logic [7:0] d;
        step(1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < SWEEP_LEN; i++) begin
            d = 8'h10 + 8'(i);
            step(1'b0, 1'b1, 4'(i), d, (i < 6) ? ~good_par(d) : good_par(d), 1'b0);
        end
        total++; if (log_full !== 1'b1) begin bad++; $display("FAIL ovf_full got=%b exp=1", log_full); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        total++; if (err_count !== 4'd6) begin bad++; $display("FAIL ovf_err got=%0d exp=6", err_count); end
        for (int i = 0; i < 4; i++) begin
            total++; if ({log_addr, log_data} !== {4'(i), 8'h10 + 8'(i)})
                begin bad++; $display("FAIL ovf_order%0d got=%h exp=%h", i, {log_addr, log_data}, {4'(i), 8'h10 + 8'(i)}); end
            step(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1);
        end
        total++; if (log_empty !== 1'b1 || overflow !== 1'b1) begin bad++; $display("FAIL ovf_after got empty=%b ovf=%b exp 1/1", log_empty, overflow); end
        // new sweep clears sticky overflow
        step(1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
        total++; if (overflow !== 1'b0 || err_count !== 4'h0) begin bad++; $display("FAIL ovf_clear got ovf=%b err=%0d exp 0/0", overflow, err_count); end
    endtask

    task automatic test_push_pop_full();
        logic [7:0] d;
        for (int i = 0; i < 4; i++) begin
            d = 8'h40 + 8'(i);
            step(1'b0, 1'b1, 4'(i), d, ~good_par(d), 1'b0);
        end
        total++; if (log_full !== 1'b1) begin bad++; $display("FAIL pp_full_before got=%b exp=1", log_full); end
        d = 8'h44;
        step(1'b0, 1'b1, 4'h4, d, ~good_par(d), 1'b1);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL pp_ovf got=%b exp=0", overflow); end
        total++; if (log_full !== 1'b1) begin bad++; $display("FAIL pp_full_after got=%b exp=1", log_full); end
        for (int i = 1; i <= 4; i++) begin
            total++; if ({log_addr, log_data} !== {4'(i), 8'h40 + 8'(i)})
                begin bad++; $display("FAIL pp_order%0d got=%h exp=%h", i, {log_addr, log_data}, {4'(i), 8'h40 + 8'(i)}); end
            step(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1);
        end
        total++; if (log_empty !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL pp_drain got empty=%b busy=%b exp 1/1", log_empty, busy); end
    endtask

    task automatic test_saturation();
        logic [7:0] d;
        logic [3:0] exp_err;
        do_reset();
        step(1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < SWEEP_LEN; i++) begin
            d = 8'($urandom);
            step(1'b0, 1'b1, 4'(i), d, ~good_par(d), 1'b0);
            if (i == 14) begin
                total++; if (err_count !== 4'd15) begin bad++; $display("FAIL sat_15 got=%0d exp=15", err_count); end
            end
        end
`ifdef PARITY_SCAN_SAT_EN
        exp_err = 4'd15;
`else
        exp_err = 4'd0;
`endif
        total++; if (err_count !== exp_err) begin bad++; $display("FAIL sat_final got=%0d exp=%0d", err_count, exp_err); end
    endtask

    task automatic test_reset_mid_sweep();
        logic [7:0] d;
        do_reset();
        step(1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            d = 8'($urandom);
            step(1'b0, 1'b1, 4'(i), d, ~good_par(d), 1'b0);
        end
        reset = 1'b1;
        model_clear();
        #1;
        total++; if (busy !== 1'b0 || err_count !== 4'h0 || log_empty !== 1'b1)
            begin bad++; $display("FAIL async_reset got busy=%b err=%0d empty=%b exp 0/0/1", busy, err_count, log_empty); end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            d = 8'($urandom);
            step(1'b0, 1'b1, 4'(i), d, ~good_par(d), 1'b0);
        end
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL mid_reset_state got busy=%b done=%b exp 0/0", busy, done); end
        total++; if (err_count !== 4'h0 || overflow !== 1'b0) begin bad++; $display("FAIL mid_reset_err got err=%0d ovf=%b exp 0/0", err_count, overflow); end
        total++; if (log_empty !== 1'b1 || log_full !== 1'b0 || {log_addr, log_data} !== 12'h000)
            begin bad++; $display("FAIL mid_reset_log got empty=%b full=%b head=%h exp 1/0/000", log_empty, log_full, {log_addr, log_data}); end
    endtask

    task automatic test_random();
        logic       st, v, p, pop;
        logic [7:0] d;
        logic [11:0] exp_head;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            st  = (n == 0) || ($urandom_range(0, 24) == 0);
            v   = $urandom_range(0, 3) != 0;
            d   = 8'($urandom);
            p   = ($urandom_range(0, 2) == 0) ? ~good_par(d) : good_par(d);
            pop = $urandom_range(0, 5) == 0;
            step(st, v, 4'($urandom), d, p, pop);
            exp_head = (m_q.size() > 0) ? m_q[0] : 12'h000;
            total++; if (busy !== (m_phase == 1) || done !== (m_phase == 2))
                begin bad++; $display("FAIL rnd_state n=%0d got busy=%b done=%b exp phase=%0d", n, busy, done, m_phase); end
            total++; if (err_count !== 4'(m_err))
                begin bad++; $display("FAIL rnd_err n=%0d got=%0d exp=%0d", n, err_count, m_err); end
            total++; if (log_empty !== (m_q.size() == 0) || log_full !== (m_q.size() == LOG_DEPTH))
                begin bad++; $display("FAIL rnd_occ n=%0d got empty=%b full=%b exp size=%0d", n, log_empty, log_full, m_q.size()); end
            total++; if (overflow !== m_ovf)
                begin bad++; $display("FAIL rnd_ovf n=%0d got=%b exp=%b", n, overflow, m_ovf); end
            total++; if ({log_addr, log_data} !== exp_head)
                begin bad++; $display("FAIL rnd_head n=%0d got=%h exp=%h", n, {log_addr, log_data}, exp_head); end
        end
    endtask

    initial begin
        test_reset();
        test_clean_sweep();
        test_two_errors();
        test_overflow();
        test_push_pop_full();
        test_saturation();
        test_reset_mid_sweep();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
